// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retired-instruction records into a FIFO and streams each as 6 words.
// Define TRACE_STALL_EN to drive stall_req (back-pressure into CPU global_en); otherwise it is tied to 0.
module commit_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  input  logic        commit_dmem_we,
  input  logic [31:0] commit_dmem_wa,
  input  logic [31:0] commit_dmem_wd,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_data,
  output logic        trace_last,
  output logic        stall_req,
  output logic        halted,
  output logic [31:0] commit_cnt,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic        dmem_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
    logic [15:0] seq;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          rec_in;
  rec_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    word_idx;
  logic          full;
  logic          capture;
  logic          push;
  logic          drop;
  logic          handshake;
  logic          pop;

  // Fullness uses registered occupancy only, so a push is dropped even when a pop happens on the same edge.
  assign full        = (count == DEPTH_W);
  assign capture     = commit && !halted;
  assign push        = capture && !full;
  assign drop        = capture && full;
  assign trace_valid = (count != '0);
  assign handshake   = trace_valid && trace_ready;
  assign trace_last  = trace_valid && (word_idx == 3'd5);
  assign pop         = handshake && (word_idx == 3'd5);
  assign head        = mem[rd_ptr];

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    rec_in         = '0;
    rec_in.pc      = commit_pc;
    rec_in.inst    = commit_inst;
    rec_in.halt    = commit_halt;
    rec_in.reg_we  = commit_reg_we;
    rec_in.dmem_we = commit_dmem_we;
    rec_in.reg_wa  = commit_reg_wa;
    rec_in.reg_wd  = commit_reg_wd;
    rec_in.dmem_wa = commit_dmem_wa;
    rec_in.dmem_wd = commit_dmem_wd;
    rec_in.seq     = commit_cnt[15:0];
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      word_idx   <= '0;
      halted     <= 1'b0;
      commit_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        commit_cnt <= commit_cnt + 32'd1;
        if (commit_halt) halted <= 1'b1;
      end
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (handshake) word_idx <= pop ? 3'd0 : word_idx + 3'd1;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the record storage is deliberately not reset; count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  always_comb begin
    trace_data = '0;
    if (trace_valid) begin
      case (word_idx)
        3'd0:    trace_data = head.pc;
        3'd1:    trace_data = head.inst;
        3'd2:    trace_data = {head.halt, head.reg_we, head.dmem_we, head.reg_wa, 8'h00, head.seq};
        3'd3:    trace_data = head.reg_wd;
        3'd4:    trace_data = head.dmem_wa;
        3'd5:    trace_data = head.dmem_wd;
        default: trace_data = '0;
      endcase
    end
  end

`ifdef TRACE_STALL_EN
  // Two free entries of margin: the CPU commit register lags global_en by one cycle.
  logic [AW:0] free_entries;
  assign free_entries = DEPTH_W - count;
  assign stall_req    = (free_entries <= (AW+1)'(1));
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: stimulus queues expected words, a negedge monitor compares handshakes.
module tb_commit_trace_buffer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_inst = '0;
  logic        commit_halt = 1'b0;
  logic        commit_reg_we = 1'b0;
  logic [4:0]  commit_reg_wa = '0;
  logic [31:0] commit_reg_wd = '0;
  logic        commit_dmem_we = 1'b0;
  logic [31:0] commit_dmem_wa = '0;
  logic [31:0] commit_dmem_wd = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_data;
  logic        trace_last;
  logic        stall_req;
  logic        halted;
  logic [31:0] commit_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .commit(commit), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_halt(commit_halt), .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa),
    .commit_reg_wd(commit_reg_wd), .commit_dmem_we(commit_dmem_we), .commit_dmem_wa(commit_dmem_wa),
    .commit_dmem_wd(commit_dmem_wd), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_data(trace_data), .trace_last(trace_last), .stall_req(stall_req), .halted(halted),
    .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [31:0] pc, inst;
    logic        halt, reg_we, dmem_we;
    logic [4:0]  wa;
    logic [31:0] wd, dwa, dwd;
  } rec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          hs_cnt = 0;
  int          last_cnt = 0;
  bit          held = 1'b0;
  logic [31:0] held_data;
  logic        held_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int i);
    rec_t r;
    r.pc      = 32'h0000_1000 + 32'(i) * 32'd4;
    r.inst    = 32'h0000_0013 | (32'(i) << 20);
    r.halt    = 1'b0;
    r.reg_we  = (i % 2) == 1;
    r.dmem_we = ((i / 2) % 2) == 1;
    r.wa      = 5'(i + 3);
    r.wd      = 32'hA000_0000 + 32'(i);
    r.dwa     = 32'h2000_0000 + 32'(i) * 32'd4;
    r.dwd     = 32'h5A5A_0000 ^ 32'(i);
    return r;
  endfunction

  task automatic expect_rec(input rec_t r, input int seq);
    logic [15:0] s;
    s = 16'(seq);
    exp_q.push_back('{r.pc, 1'b0});
    exp_q.push_back('{r.inst, 1'b0});
    exp_q.push_back('{{r.halt, r.reg_we, r.dmem_we, r.wa, 8'h00, s}, 1'b0});
    exp_q.push_back('{r.wd, 1'b0});
    exp_q.push_back('{r.dwa, 1'b0});
    exp_q.push_back('{r.dwd, 1'b1});
  endtask

  task automatic set_inputs(input rec_t r, input logic c);
    commit         = c;
    commit_pc      = r.pc;
    commit_inst    = r.inst;
    commit_halt    = r.halt;
    commit_reg_we  = r.reg_we;
    commit_reg_wa  = r.wa;
    commit_reg_wd  = r.wd;
    commit_dmem_we = r.dmem_we;
    commit_dmem_wa = r.dwa;
    commit_dmem_wd = r.dwd;
  endtask

  // One-cycle commit pulse; returns 1 time unit after the sampling edge.
  task automatic drive(input rec_t r);
    set_inputs(r, 1'b1);
    @(posedge clk);
    #1;
    commit = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    commit = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    hs_cnt   = 0;
    last_cnt = 0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !trace_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  // Monitor: compares every handshake against the scoreboard and checks stability while stalled.
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(trace_valid), 32'd1);
        check("hold_data", trace_data, held_data);
        check("hold_last", 32'(trace_last), 32'(held_last));
      end
      if (trace_valid && trace_ready) begin
        hs_cnt++;
        if (trace_last) last_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", trace_data, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("word_data", trace_data, e.data);
          check("word_last", 32'(trace_last), 32'(e.last));
        end
      end
      held      = trace_valid && !trace_ready;
      held_data = trace_data;
      held_last = trace_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(trace_valid), 32'd0);
    check("rst_data", trace_data, 32'd0);
    check("rst_last", 32'(trace_last), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_commit_cnt", commit_cnt, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // Single record, ready high: w2 = 0x4100_0000
    r = '{32'h0, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd0, 32'd0};
    trace_ready = 1'b1;
    expect_rec(r, 0);
    drive(r);
    check("latency_valid", 32'(trace_valid), 32'd1);
    check("latency_w0", trace_data, 32'd0);
    wait_drain(50);
    check("t1_commit_cnt", commit_cnt, 32'd1);
    check("t1_handshakes", 32'(hs_cnt), 32'd6);
    check("t1_last_pulses", 32'(last_cnt), 32'd1);

`ifndef TRACE_STALL_EN
    // Overflow: DEPTH+3 commits with the host stalled; the halt record among the drops must not set halted
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      r = mk(i);
      if (i == DEPTH) r.halt = 1'b1;
      if (i < DEPTH) expect_rec(r, i);
      drive(r);
    end
    check("ovf_commit_cnt", commit_cnt, 32'(DEPTH));
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    check("ovf_halted", 32'(halted), 32'd0);
    check("ovf_stall", 32'(stall_req), 32'd0);
    // Push while full on the same edge as the pop of the head record is still dropped
    trace_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    drive(mk(99));
    check("pushpop_drop_cnt", 32'(drop_cnt), 32'd4);
    check("pushpop_commit_cnt", commit_cnt, 32'(DEPTH));
    wait_drain(200);
    check("ovf_handshakes", 32'(hs_cnt), 32'(6 * DEPTH));
    check("ovf_last_pulses", 32'(last_cnt), 32'(DEPTH));
`else
    // Back-pressure: CPU model honours stall_req with one cycle of lag
    begin
      int  issued, captured, cycles;
      bit  en_prev, seen, prev_commit;
      do_reset();
      trace_ready = 1'b0;
      issued = 0; captured = 0; cycles = 0;
      en_prev = 1'b1; seen = 1'b0; prev_commit = 1'b0;
      while (issued < DEPTH + 3 && cycles < 400) begin
        if (cycles == 25) trace_ready = 1'b1;
        if (en_prev) begin
          r = mk(issued);
          expect_rec(r, issued);
          set_inputs(r, 1'b1);
          issued++;
        end else begin
          commit = 1'b0;
        end
        prev_commit = commit;
        @(posedge clk);
        #1;
        commit = 1'b0;
        if (prev_commit) captured++;
        if (stall_req && !seen) begin
          seen = 1'b1;
          check("stall_at_occupancy", 32'(captured), 32'(DEPTH - 1));
        end
        en_prev = !stall_req;
        cycles++;
      end
      check("stall_seen", 32'(seen), 32'd1);
      trace_ready = 1'b1;
      wait_drain(300);
      check("stall_drop_cnt", 32'(drop_cnt), 32'd0);
      check("stall_commit_cnt", commit_cnt, 32'(DEPTH + 3));
    end
`endif

    // Halt: only the halt record is captured and streamed
    do_reset();
    trace_ready = 1'b1;
    r = mk(0);
    r.inst = 32'h0010_0073;
    r.halt = 1'b1;
    expect_rec(r, 0);
    drive(r);
    for (int i = 1; i <= 4; i++) drive(mk(i));
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_commit_cnt", commit_cnt, 32'd1);
    check("halt_drop_cnt", 32'(drop_cnt), 32'd0);
    wait_drain(50);
    check("halt_last_pulses", 32'(last_cnt), 32'd1);

    // Random ready during a 3-record drain
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_rec(mk(10 + i), i);
      drive(mk(10 + i));
    end
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !trace_valid) break;
      trace_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    trace_ready = 1'b1;
    wait_drain(50);
    check("rand_handshakes", 32'(hs_cnt), 32'd18);
    check("rand_last_pulses", 32'(last_cnt), 32'd3);

    // Reset while w2 is pending discards the record; the next record streams from w0
    do_reset();
    trace_ready = 1'b0;
    r = mk(5);
    expect_rec(r, 0);
    drive(r);
    trace_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    trace_ready = 1'b0;
    check("mid_w2_pending", trace_data, {r.halt, r.reg_we, r.dmem_we, r.wa, 8'h00, 16'h0000});
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(trace_valid), 32'd0);
    check("mid_rst_commit_cnt", commit_cnt, 32'd0);
    check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("mid_rst_halted", 32'(halted), 32'd0);
    rst      = 1'b0;
    hs_cnt   = 0;
    last_cnt = 0;
    trace_ready = 1'b1;
    expect_rec(mk(6), 0);
    drive(mk(6));
    wait_drain(50);
    check("post_rst_handshakes", 32'(hs_cnt), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Receiving end of the CPU's commit debug bus: samples every retired-instruction record (`commit`, `commit_pc`, `commit_inst`, `commit_halt`, register and data-memory write fields) into a FIFO. The FIFO is drained to the host debug link as a 6-word stream over a valid/ready handshake. It sits beside the CPU in the top-level debug path and also keeps a retired-instruction count, a dropped-record count and a halt flag. Optionally it back-pressures the CPU through `global_en` so that no record is lost.

## Interface
- `DEPTH`, 8, FIFO capacity in records; power of two, ≥ 4.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `commit` in 1: record valid this cycle.
- `commit_pc` in 32: PC of the retired instruction.
- `commit_inst` in 32: the retired instruction.
- `commit_halt` in 1: the retired instruction is the halt instruction.
- `commit_reg_we` in 1: register-file write enable.
- `commit_reg_wa` in 5: register-file write address.
- `commit_reg_wd` in 32: register-file write data.
- `commit_dmem_we` in 1: data-memory write enable.
- `commit_dmem_wa` in 32: data-memory write address.
- `commit_dmem_wd` in 32: data-memory write data.
- `trace_valid` out 1: `trace_data` holds a valid word.
- `trace_ready` in 1: host accepts the word.
- `trace_data` out 32: stream word.
- `trace_last` out 1: the current word is word 5 of a record.
- `stall_req` out 1: request to deassert CPU `global_en`.
- `halted` out 1: sticky; a halt record has been captured.
- `commit_cnt` out 32: records captured (wraps).
- `drop_cnt` out 16: records dropped (saturates at 0xFFFF).

## Operation
- Capture condition: `commit && !halted`.
  - If the FIFO is not full: push the record and increment `commit_cnt`.
  - If the FIFO is full: drop the record and increment `drop_cnt`, saturating.
- "Full" is judged on the registered occupancy before any same-cycle pop. A push while full is dropped even if a pop occurs in the same cycle.
- Sequence number: a pushed record stores `commit_cnt[15:0]` as it was before the increment. The first record is 0.
- Halt: a captured record with `commit_halt = 1` sets `halted` on that edge. Afterwards all `commit` pulses are ignored: no push, no count, no drop.
- A halt record that arrives while the FIFO is full is dropped and does not set `halted`.
- Stream format, one record = 6 words sent in order:
  - w0 = pc
  - w1 = inst
  - w2 = {halt, reg_we, dmem_we, reg_wa[4:0], 8'h00, seq[15:0]}
  - w3 = reg_wd
  - w4 = dmem_wa
  - w5 = dmem_wd
- Serializer: a word index counts 0..5.
  - `trace_valid` = FIFO not empty.
  - `trace_data` = the word at the current index of the head record.
  - On `trace_valid && trace_ready` the index increments.
  - On the handshake at index 5 (`trace_last`): the index wraps to 0 and the head record is popped.
- Words and `trace_valid` hold stable while `trace_ready` is low.
- `stall_req` = free entries ≤ 1. Two entries of margin are needed because the CPU's commit register lags `global_en` by one cycle.

## Timing
- Reset values: `trace_valid` 0, `trace_data` 0, `trace_last` 0, `stall_req` 0, `halted` 0, `commit_cnt` 0, `drop_cnt` 0. FIFO empty; word index 0.
- Reset mid-record discards all buffered and partially sent records. The host must resynchronize on the next w0 after reset.
- Push latency: a record captured at edge N is visible as w0 from cycle N+1. There is no fall-through.
- Throughput: one word per cycle with `trace_ready` held high. A new record can start on the cycle after the previous `trace_last` handshake.
- Simultaneous push and pop when not full: occupancy is unchanged and both take effect.
- Pointers wrap modulo `DEPTH`. Occupancy is held in a counter of width log2(DEPTH)+1.
- Counter updates, `halted` and `stall_req` are all registered or derived from registered occupancy. No combinational path exists from `commit*` to any output.

## Configuration
- `TRACE_STALL_EN` defined: `stall_req` is driven as described above. The top level ANDs `~stall_req` into `global_en`, and `drop_cnt` remains 0 in normal operation.
- `TRACE_STALL_EN` undefined: `stall_req` is tied to 0. The CPU never stalls, and the overflow drop path is the only protection against loss.

## Test plan
- Reset, then one commit (pc 0x0000_0000, inst 0x0010_0093, reg_we 1, wa 1, wd 1), `trace_ready` high → next cycle w0..w5 = 0, 0x00100093, 0x4100_0000, 1, 0, 0. `trace_last` high on w5; `commit_cnt` = 1.
- `trace_ready` low; DEPTH+3 back-to-back commits with the macro undefined → `commit_cnt` = DEPTH, `drop_cnt` = 3. Draining yields seq 0..DEPTH-1 in order.
- Same stimulus with `TRACE_STALL_EN` defined → `stall_req` rises when occupancy reaches DEPTH-1. A CPU model that honours the stall produces `drop_cnt` = 0.
- Commit with `commit_halt` = 1 (inst 0x0010_0073), followed by 4 more commits → `halted` = 1, `commit_cnt` = 1. w2 bit 31 is set, and only one record is streamed.
- `trace_ready` toggled randomly during a 3-record drain → every word is stable while stalled. Exactly 18 handshakes occur and 3 `trace_last` pulses.
- Assert `rst` while w2 of a record is pending → the next cycle shows `trace_valid` 0 and all counters 0. A subsequent commit streams from w0.
